decoder_scan_sequencer: RTL and testbench

- Upstream stage of the 2-to-4 decoder.
- Generates the 2-bit select code that the decoder turns into a one-hot line.
- Steps the code through all positions (0,1,2,3), holding each for a programmable dwell time, in one-shot or continuous mode.
- Typical use: scanning 4 LED digits or keypad rows.

---
 rtl/decoder_pkg.sv | 12 +
 rtl/dwell_counter.sv | 36 +++
 rtl/decoder_scan_sequencer.sv | 134 +++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder scan sequencer and its bench.
package decoder_pkg;

    localparam int unsigned DEF_SEL_W = 2;
    localparam int unsigned NUM_POS   = 2 ** DEF_SEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/dwell_counter.sv
// Per-position dwell counter: counts 0..limit, then pulses tc and wraps to 0.
module dwell_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tc    = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == limit) begin
                tc    = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a select code through all decoder positions with a programmable dwell.
// Optional SCAN_PAUSE_EN adds a pause input that freezes the scan.
module decoder_scan_sequencer
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = DEF_SEL_W,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               oneshot,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_PAUSE_EN
    input  logic               pause,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [SEL_W-1:0] LAST_SEL = '1;

    state_e             state_q,       state_d;
    logic [SEL_W-1:0]   sel_q,         sel_d;
    logic               sel_valid_q,   sel_valid_d;
    logic               busy_q,        busy_d;
    logic               frame_done_q,  frame_done_d;
    logic               stop_pend_q,   stop_pend_d;
    logic [DWELL_W-1:0] dwell_lat_q,   dwell_lat_d;
    logic               oneshot_lat_q, oneshot_lat_d;

    logic pause_i;
    logic stop_now;
    logic cnt_clear;
    logic cnt_enable;
    logic pos_end;

`ifdef SCAN_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    // A stop arriving on the final cycle of a position still ends the scan there.
    assign stop_now   = stop_pend_q | stop;
    assign cnt_clear  = (state_q == IDLE);
    assign cnt_enable = (state_q == SCAN) && !pause_i;

    dwell_counter #(
        .W (DWELL_W)
    ) u_dwell_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .limit  (dwell_lat_q),
        .tc     (pos_end)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        sel_valid_d   = sel_valid_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        stop_pend_d   = stop_pend_q;
        dwell_lat_d   = dwell_lat_q;
        oneshot_lat_d = oneshot_lat_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d       = SCAN;
                    sel_d         = '0;
                    sel_valid_d   = 1'b1;
                    busy_d        = 1'b1;
                    stop_pend_d   = 1'b0;
                    dwell_lat_d   = dwell;
                    oneshot_lat_d = oneshot;
                end
            end
            SCAN: begin
                stop_pend_d = stop_now;
                if (pos_end) begin
                    frame_done_d = (sel_q == LAST_SEL);
                    if (stop_now || ((sel_q == LAST_SEL) && oneshot_lat_q)) begin
                        state_d     = IDLE;
                        sel_d       = '0;
                        sel_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        stop_pend_d = 1'b0;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                        if (sel_q == LAST_SEL) dwell_lat_d = dwell;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            sel_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            stop_pend_q   <= 1'b0;
            dwell_lat_q   <= '0;
            oneshot_lat_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            sel_valid_q   <= sel_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            stop_pend_q   <= stop_pend_d;
            dwell_lat_q   <= dwell_lat_d;
            oneshot_lat_q <= oneshot_lat_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer; define SCAN_PAUSE_EN to cover pause.
module tb_decoder_scan_sequencer;
    import decoder_pkg::*;

    localparam int unsigned SEL_W   = DEF_SEL_W;
    localparam int unsigned DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               oneshot = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
`ifdef SCAN_PAUSE_EN
    logic               pause = 1'b0;
`endif
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               busy;
    logic               frame_done;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    decoder_scan_sequencer #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .oneshot    (oneshot),
        .dwell      (dwell),
`ifdef SCAN_PAUSE_EN
        .pause      (pause),
`endif
        .sel        (sel),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Packed as {sel, sel_valid, busy, frame_done}.
    task automatic expect_out(input string tag, input int unsigned s, input logic v,
                              input logic b, input logic f);
        check(tag, 32'({sel, sel_valid, busy, frame_done}),
              32'({SEL_W'(s), v, b, f}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        expect_out("reset_state", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("idle_after_reset", 0, 1'b0, 1'b0, 1'b0);

        // Reset mid-scan at sel=2
        dwell = 8'd0; oneshot = 1'b0;
        pulse_start();
        expect_out("rst_scan_s0", 0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        expect_out("rst_scan_s2", 2, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("rst_mid_scan", 0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("rst_stays_idle", 0, 1'b0, 1'b0, 1'b0);

        // Oneshot, dwell=2
        dwell = 8'd2; oneshot = 1'b1;
        pulse_start();
        oneshot = 1'b0;
        for (int i = 0; i < 12; i++) begin
            expect_out("oneshot_seq", i / 3, 1'b1, 1'b1, 1'b0);
            tick();
        end
        expect_out("oneshot_done", 0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("oneshot_idle", 0, 1'b0, 1'b0, 1'b0);

        // Continuous, dwell=0, then dwell=1 after the wrap
        dwell = 8'd0; oneshot = 1'b0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            expect_out("cont_d0", i % NUM_POS, 1'b1, 1'b1, i == 4);
            if (i == 5) dwell = 8'd1;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            expect_out("cont_d1", i / 2, 1'b1, 1'b1, i == 0);
            tick();
        end
        expect_out("cont_d1_wrap", 0, 1'b1, 1'b1, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_out("cont_stop_hold", 0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("cont_stop_idle", 0, 1'b0, 1'b0, 1'b0);

        // Stop on 2nd cycle of position 1, dwell=3
        dwell = 8'd3; oneshot = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            expect_out("stop_p0", 0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        expect_out("stop_p1_c0", 1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("stop_p1_c1", 1, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_out("stop_p1_c2", 1, 1'b1, 1'b1, 1'b0);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_out("stop_idle", 0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("stop_stays_idle", 0, 1'b0, 1'b0, 1'b0);

        // start+stop together in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        expect_out("start_stop_idle", 0, 1'b0, 1'b0, 1'b0);

        // start during SCAN ignored; stop on final cycle of position 3
        dwell = 8'd0; oneshot = 1'b0;
        pulse_start();
        expect_out("restart_s0", 0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("restart_s1", 1, 1'b1, 1'b1, 1'b0);
        start = 1'b1; oneshot = 1'b1; dwell = 8'd5;
        tick();
        start = 1'b0; oneshot = 1'b0;
        expect_out("restart_ignored", 2, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("restart_s3", 3, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_out("stop_last_done", 0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("stop_last_idle", 0, 1'b0, 1'b0, 1'b0);

`ifdef SCAN_PAUSE_EN
        // Pause at sel=2 for 5 cycles, dwell=1
        dwell = 8'd1; oneshot = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            expect_out("pause_pre", i / 2, 1'b1, 1'b1, 1'b0);
            tick();
        end
        expect_out("pause_s2_c0", 2, 1'b1, 1'b1, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("pause_hold", 2, 1'b1, 1'b1, 1'b0);
        end
        tick();
        pause = 1'b0;
        expect_out("pause_rel_c0", 2, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("pause_rel_c1", 2, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("pause_adv", 3, 1'b1, 1'b1, 1'b0);
        pause = 1'b1; stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_out("pause_stop_hold0", 3, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("pause_stop_hold1", 3, 1'b1, 1'b1, 1'b0);
        pause = 1'b0;
        tick();
        expect_out("pause_stop_c1", 3, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("pause_stop_done", 0, 1'b0, 1'b0, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
